// File: rtl/countdown_timer_modulo.sv
// Programmable down-counting timer: a modulo-M prescaler strobes tick, and each
// tick decrements a W-bit count under an IDLE/RUN/PAUSE/DONE control FSM.
module countdown_timer_modulo #(
    parameter int M = 20,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         enable,
    input  logic         load,
    input  logic         start,
    input  logic         pause,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] Q,
    output logic [1:0]   state,
    output logic         tick,
    output logic         borrow,
    output logic         done
);

    function automatic int clogb2(input int value);
        int v;
        int w;
        v = value;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    localparam int             PW    = clogb2(M - 1);
    localparam logic [PW-1:0]  P_MAX = PW'(M - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        state_reg;
    logic [W-1:0]  q_reg;
    logic [PW-1:0] p_reg;
    logic          p_zero;
    logic          q_one;

    assign p_zero = (p_reg == '0);
    assign q_one  = (q_reg == W'(1));

    // Reset and load discard the prescaler phase, so neither may emit a strobe.
    assign tick   = (state_reg == RUN) & ~pause & enable & p_zero & ~aclr & ~load;
    assign borrow = tick & q_one;
    assign done   = (state_reg == DONE);
    assign state  = state_reg;
    assign Q      = q_reg;

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            p_reg     <= P_MAX;
        end else if (load) begin
            state_reg <= IDLE;
            q_reg     <= load_value;
            p_reg     <= P_MAX;
        end else begin
            case (state_reg)
                IDLE: begin
                    p_reg <= P_MAX;
                    if (start) begin
                        state_reg <= (q_reg != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_reg <= PAUSE;
                    end else if (q_reg == '0) begin
                        // Unreachable in normal use; finish rather than underflow.
                        state_reg <= DONE;
                    end else if (enable) begin
                        if (p_zero) begin
                            p_reg <= P_MAX;
                            if (q_one) begin
                                q_reg     <= '0;
                                state_reg <= DONE;
                            end else begin
                                q_reg <= q_reg - W'(1);
                            end
                        end else if (p_reg > P_MAX) begin
                            p_reg <= P_MAX;
                        end else begin
                            p_reg <= p_reg - PW'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    q_reg <= '0;
                    p_reg <= P_MAX;
                end
            endcase
        end
    end

endmodule

// File: doc/countdown_timer_modulo.md
Name: countdown_timer_modulo

Overview:
- Programmable down-counting timer. It loads a count value, then decrements it once every M enabled clock cycles until it reaches zero.
- It is the count-down counterpart of the team's modulo-K up counter with rollover flag.
- An internal modulo-M prescaler produces a tick strobe, and a W-bit main counter counts ticks down to zero under a four-state control FSM.
- Intended for board-level timers on KEY/LEDR tops: seconds countdown, delay generation, timeouts.

Parameters:
- M, 20, prescaler modulus: enabled cycles per tick. Must be >= 2.
- W, 8, width of the main down counter and of load_value.
- PW (localparam), ceil(log2(M)): prescaler width, computed with the codebase's clogb2(M-1) function.

Ports:
- clk  input  1  rising-edge clock.
- aclr  input  1  reset. Synchronous, active-high; sampled on rising clk only.
- enable  input  1  count enable. Prescaler advances only when high in RUN.
- load  input  1  synchronous load of load_value. Highest priority after reset.
- start  input  1  start/resume request, level-sampled.
- pause  input  1  pause request, level-sampled.
- load_value  input  W  count loaded into Q.
- Q  output  W  current remaining count, registered.
- state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- tick  output  1  combinational strobe: prescaler wraps this cycle.
- borrow  output  1  combinational strobe: tick while Q==1 (final decrement).
- done  output  1  high whenever state==DONE.

Behaviour:
- Reset (aclr=1 at posedge) overrides everything:
  - state=IDLE, Q=0, prescaler P=M-1.
  - tick=0, borrow=0, done=0.
- Priority per edge: aclr > load > FSM transition.
- load=1, any state:
  - Q<=load_value, P<=M-1, state<=IDLE.
  - start and pause are ignored that cycle.
- IDLE:
  - start=1 and Q!=0 -> RUN.
  - start=1 and Q==0 -> DONE.
  - Otherwise hold; P stays M-1.
- RUN, evaluated in this order:
  - pause=1 -> PAUSE. P and Q hold; tick=0 that cycle.
  - enable=0 -> hold everything; tick=0.
  - enable=1 and P!=0 -> P<=P-1.
  - enable=1 and P==0:
    - tick=1 and P<=M-1.
    - If Q==1: Q<=0, borrow=1, state<=DONE.
    - Else: Q<=Q-1.
  - start is ignored in RUN.
- PAUSE:
  - start=1 -> RUN, resuming with the held P and Q; no prescaler restart.
  - pause has no further effect.
- DONE:
  - Q=0, P=M-1, done=1; start and pause are ignored.
  - Exit only via load (-> IDLE) or reset.
- tick = (state==RUN) & ~pause & enable & (P==0). borrow = tick & (Q==1). Both are single-cycle, combinational from registers and inputs.
- Timing: from the first RUN cycle, the Nth tick occurs on the (N*M)th enabled non-paused RUN cycle.
  - With Q loaded to V, DONE is entered at the edge ending enabled RUN cycle V*M; done is visible the next cycle.
- Arithmetic:
  - Q never underflows; Q==0 in RUN is unreachable.
  - If it occurs anyway (defensive), force state<=DONE next edge without decrementing.
  - P never exceeds M-1; values M..2^PW-1 reload to M-1.
- Simultaneous inputs:
  - start & pause in IDLE: start wins (-> RUN).
  - start & pause in RUN: pause wins.
  - start & pause in PAUSE: start wins (-> RUN).
- Reset or load mid-count discards the prescaler phase. No tick or borrow is emitted on the edge they act on.

Test Plan:
- Reset: aclr=1 for 2 cycles with random inputs -> state=00, Q=0, done=0, tick=0, borrow=0. P reloads: after load/start, the first tick arrives 20 cycles later.
- Basic countdown, M=20, W=8: load_value=3, load pulse, start pulse, enable=1 -> tick on RUN cycles 20, 40, 60. Q goes 3->2->1->0. borrow=1 only on cycle 60. state=DONE and done=1 from cycle 61.
- Enable gating: same as above with enable toggling 1/0 each cycle -> tick every 40 clocks; DONE after 120 RUN clocks. tick never asserted while enable=0.
- Pause/resume: load 2, run 25 enabled cycles (Q=1, P=14), pause for 10 cycles -> Q and P frozen, tick=0. Then start -> next tick after 15 cycles, then DONE.
- Zero and simultaneous inputs:
  - load_value=0 then start -> DONE next edge, no tick or borrow.
  - In RUN, start=pause=1 -> PAUSE.
- Mid-operation override: in RUN with Q=5, P=7, assert load with value 9 -> IDLE, Q=9, P=19. Same scenario with aclr instead -> IDLE, Q=0. In DONE, start is ignored; load 4 -> IDLE, Q=4.
